// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave register file.
package apb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } slave_state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// Word-addressed register storage: byte-strobed synchronous write,
// combinational read, synchronous clear on reset.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         wstrb,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with a small register file and configurable wait states.
// Define APB_SLAVE_PROT_CHECK_EN to make register index 0 privileged (pprot[0]).
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB    = bytes_per_word(DATA_WIDTH);
  localparam int OFF   = offset_bits(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer is captured when IDLE sees psel with penable low;
  // it completes in the ACCESS cycle where pready is high, and a drop of psel
  // during ACCESS abandons it without a response or register update.
  slave_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;
  logic                  done;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [2:0]            prot_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        prot_q  <= pprot;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode works on the captured address so bus changes after setup are ignored.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misalign;
  logic                  range_err;
  logic                  prot_err;
  logic                  err;
  logic                  unused_prot;

  assign idx       = addr_q >> OFF;
  assign range_err = ({1'b0, idx} >= (ADDR_WIDTH+1)'(DEPTH));

  generate
    if (OFF > 0) begin : g_align
      assign misalign = |addr_q[OFF-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

`ifdef APB_SLAVE_PROT_CHECK_EN
  assign prot_err    = (idx == '0) && !prot_q[0];
  assign unused_prot = ^prot_q[2:1];
`else
  assign prot_err    = 1'b0;
  assign unused_prot = ^prot_q;
`endif

  assign err = misalign | range_err | prot_err;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign mem_we = done && write_q && !err;

  apb_regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (pclk),
    .rst   (preset),
    .we    (mem_we),
    .waddr (idx[IDX_W-1:0]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (idx[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign pready  = done;
  assign pslverr = done && err;
  assign prdata  = (done && !write_q && !err) ? mem_rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: one zero-wait and one three-wait slave on a shared bus.
module tb_apb_slave_regfile;

  logic        pclk;
  logic        preset;
  logic        psel0, psel3;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  int n_tests = 0;
  int n_fail  = 0;

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sync;
    @(posedge pclk);
    #1;
  endtask

  // Starts at posedge+1 with the setup phase; returns at posedge+1 with the bus idle.
  task automatic apb_xfer(input bit sel3, input bit wr, input logic [9:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input bit scramble,
                          output logic [31:0] rdata, output logic err, output int waits);
    bit got;
    psel0   = !sel3;
    psel3   = sel3;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    sync();
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    rdata = '0;
    err   = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge pclk);
      if (sel3 ? pready3 : pready0) begin
        rdata = sel3 ? prdata3 : prdata0;
        err   = sel3 ? pslverr3 : pslverr0;
        got   = 1'b1;
      end else begin
        waits++;
        if (scramble) pwdata = ~data;
        sync();
      end
    end
    if (!got) chk("pready_timeout", 32'(sel3 ? pready3 : pready0), 32'd1);
    sync();
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input bit sel3, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [2:0] prot, input bit scramble,
                        input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(sel3, 1'b1, addr, data, strb, prot, scramble, rd, e, w);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  task automatic rd_chk(input string tag, input bit sel3, input logic [9:0] addr,
                        input logic [2:0] prot, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(sel3, 1'b0, addr, 32'h0BAD_0BAD, 4'b1111, prot, 1'b0, rd, e, w);
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  initial begin
    preset  = 1'b1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pprot   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_pslverr0", 32'(pslverr0), 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_pready3", 32'(pready3), 32'd0);
    chk("rst_prdata3", prdata3, 32'd0);
    sync();

    // zero-wait write then read
    wr_chk("w0_wr", 1'b0, 10'h010, 32'h002A_4C23, 4'b1111, 3'b001, 1'b0, 1'b0, 0);
    rd_chk("w0_rd", 1'b0, 10'h010, 3'b001, 32'h002A_4C23, 1'b0, 0);

    // byte strobes, including an all-zero strobe
    wr_chk("strb_pre", 1'b0, 10'h004, 32'hFFFF_FFFF, 4'b1111, 3'b001, 1'b0, 1'b0, 0);
    wr_chk("strb_wr", 1'b0, 10'h004, 32'h1234_5678, 4'b0101, 3'b001, 1'b0, 1'b0, 0);
    rd_chk("strb_rd", 1'b0, 10'h004, 3'b001, 32'hFF34_FF78, 1'b0, 0);
    wr_chk("strb0_wr", 1'b0, 10'h004, 32'h0000_0000, 4'b0000, 3'b001, 1'b0, 1'b0, 0);
    rd_chk("strb0_rd", 1'b0, 10'h004, 3'b001, 32'hFF34_FF78, 1'b0, 0);

    // decode errors
    rd_chk("misalign_rd", 1'b0, 10'h07D, 3'b001, 32'h0, 1'b1, 0);
    wr_chk("range_wr", 1'b0, 10'h040, 32'hDEAD_BEEF, 4'b1111, 3'b001, 1'b0, 1'b1, 0);
    rd_chk("range_rb", 1'b0, 10'h000, 3'b001, 32'h0, 1'b0, 0);
    rd_chk("last_idx_rd", 1'b0, 10'h03C, 3'b001, 32'h0, 1'b0, 0);

    // wait states, with pwdata disturbed during the wait phase
    wr_chk("wait_wr", 1'b1, 10'h010, 32'hCAFE_F00D, 4'b1111, 3'b001, 1'b1, 1'b0, 3);
    rd_chk("wait_rd", 1'b1, 10'h010, 3'b001, 32'hCAFE_F00D, 1'b0, 3);

    // reset during the wait phase of a write
    psel3   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 10'h008;
    pwdata  = 32'h55AA_55AA;
    pstrb   = 4'b1111;
    pprot   = 3'b001;
    sync();
    penable = 1'b1;
    @(negedge pclk);
    chk("rstmid_waiting", 32'(pready3), 32'd0);
    sync();
    preset = 1'b1;
    sync();
    preset  = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("rstmid_pready", 32'(pready3), 32'd0);
    chk("rstmid_pslverr", 32'(pslverr3), 32'd0);
    chk("rstmid_prdata", prdata3, 32'd0);
    sync();
    rd_chk("rstmid_rb", 1'b1, 10'h008, 3'b001, 32'h0, 1'b0, 3);
    rd_chk("rstmid_clr", 1'b1, 10'h010, 3'b001, 32'h0, 1'b0, 3);

    // psel dropped mid-ACCESS, then back-to-back transfers
    psel3   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 10'h00C;
    pwdata  = 32'h1111_1111;
    pstrb   = 4'b1111;
    pprot   = 3'b001;
    sync();
    penable = 1'b1;
    sync();
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 32'(pready3), 32'd0);
    sync();
    rd_chk("abort_rb", 1'b1, 10'h00C, 3'b001, 32'h0, 1'b0, 3);
    wr_chk("b2b_wr", 1'b1, 10'h00C, 32'h2222_2222, 4'b1111, 3'b001, 1'b0, 1'b0, 3);
    rd_chk("b2b_rd", 1'b1, 10'h00C, 3'b001, 32'h2222_2222, 1'b0, 3);

`ifdef APB_SLAVE_PROT_CHECK_EN
    wr_chk("prot_denied_wr", 1'b0, 10'h000, 32'h0BAD_F00D, 4'b1111, 3'b000, 1'b0, 1'b1, 0);
    rd_chk("prot_denied_rb", 1'b0, 10'h000, 3'b001, 32'h0, 1'b0, 0);
    wr_chk("prot_ok_wr", 1'b0, 10'h000, 32'h0BAD_F00D, 4'b1111, 3'b001, 1'b0, 1'b0, 0);
    rd_chk("prot_ok_rb", 1'b0, 10'h000, 3'b001, 32'h0BAD_F00D, 1'b0, 0);
    rd_chk("prot_denied_rd", 1'b0, 10'h000, 3'b000, 32'h0, 1'b1, 0);
`else
    wr_chk("prot_ignored_wr", 1'b0, 10'h000, 32'h0BAD_F00D, 4'b1111, 3'b000, 1'b0, 1'b0, 0);
    rd_chk("prot_ignored_rd", 1'b0, 10'h000, 3'b000, 32'h0BAD_F00D, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
